// File: rtl/spike_encoder.sv
// Purpose: turns one accepted vector of channel values into a gamma wave (grst pulse, then 2^WRES-wide spikes starting at t = value).
// Latency: grst one cycle after accept, wave t=0 two cycles after accept, wave_done GAMMA_LEN+1 cycles after accept.
// Backpressure: in_ready is high only in IDLE or on the last wave cycle, so a held in_valid yields back-to-back waves every GAMMA_LEN+1 cycles.
module spike_encoder #(
  parameter int INP       = 16,
  parameter int TRES      = 3,
  parameter int WRES      = 3,
  parameter int GAMMA_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INP-1:0][TRES-1:0]  in_vals,
  input  logic [INP-1:0]            in_nospike,
  output logic                      grst,
  output logic [INP-1:0]            input_spikes,
  output logic                      wave_done,
  output logic                      busy
);

  localparam int PW = 2 ** WRES;
  // Wave-time counter width; kept at least 1 bit wide.
  localparam int TW = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
  // Spike end (value + PW - 1) is formed one bit wider than its operands so it never wraps.
  localparam int CW = ((TRES > WRES) ? TRES : WRES) + 1;
  // Common width for comparing t against the spike window.
  localparam int XW = (CW > TW) ? CW : TW;
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA_LEN - 1);

  // A wave too short to hold the latest possible spike is a configuration error.
  generate
    if (GAMMA_LEN < (2 ** TRES) - 1 + PW) begin : g_len_check
      $error("spike_encoder: GAMMA_LEN must be >= 2**TRES - 1 + 2**WRES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GRST = 2'd1,
    S_WAVE = 2'd2
  } state_t;

  state_t                     state_q;
  state_t                     state_nxt;
  logic [TW-1:0]              t_q;
  logic [TW-1:0]              t_nxt;
  logic                       accept;
  logic [INP-1:0][TRES-1:0]   vals_q;
  logic [INP-1:0]             nospike_q;
  logic [INP-1:0]             spikes_nxt;
  logic                       grst_nxt;
  logic                       wave_done_nxt;
  logic                       busy_nxt;

  // True when wave time t lies inside the PW-cycle window starting at v.
  function automatic logic spike_on(input logic [TRES-1:0] v, input logic [TW-1:0] t);
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    lo = CW'(v);
    hi = lo + CW'(PW - 1);
    return (XW'(t) >= XW'(lo)) && (XW'(t) <= XW'(hi));
  endfunction

  // Next-state, wave-time and handshake decode.
  always_comb begin
    state_nxt = state_q;
    t_nxt     = '0;
    accept    = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_GRST;
        end
      end
      S_GRST: begin
        // t stays 0 so the first WAVE cycle is t=0.
        state_nxt = S_WAVE;
      end
      S_WAVE: begin
        if (t_q == T_LAST) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = S_GRST;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          t_nxt = t_q + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from next state so every output is registered.
  // Holding registers are stable whenever the next state is WAVE, since capture only leads to GRST.
  always_comb begin
    spikes_nxt    = '0;
    grst_nxt      = (state_nxt == S_GRST);
    wave_done_nxt = (state_nxt == S_WAVE) && (t_nxt == T_LAST);
    busy_nxt      = (state_nxt != S_IDLE);
    if (state_nxt == S_WAVE) begin
      for (int i = 0; i < INP; i++) begin
        spikes_nxt[i] = !nospike_q[i] && spike_on(vals_q[i], t_nxt);
      end
    end
  end

  // FSM state and wave-time register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_nxt;
      t_q     <= t_nxt;
    end
  end

  // Vector capture on accept; inputs are ignored at every other time.
  always_ff @(posedge clk) begin
    if (rst) begin
      vals_q    <= '0;
      nospike_q <= '0;
    end else if (accept) begin
      vals_q    <= in_vals;
      nospike_q <= in_nospike;
    end
  end

  // Registered outputs; reset clears them at the next edge, aborting any wave without wave_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      grst         <= 1'b0;
      input_spikes <= '0;
      wave_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      grst         <= grst_nxt;
      input_spikes <= spikes_nxt;
      wave_done    <= wave_done_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: default configuration plus a TRES=2/WRES=4/GAMMA_LEN=19 instance.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled at that same point.
// Expected values are hand-computed constants or derived from the channel values fed in.
module tb_spike_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][2:0]  in_vals;
  logic [15:0]       in_nospike;
  logic              grst;
  logic [15:0]       input_spikes;
  logic              wave_done;
  logic              busy;

  // Sweep instance: INP=2, TRES=2, WRES=4, GAMMA_LEN=19.
  logic              rst2;
  logic              in_valid2;
  logic              in_ready2;
  logic [1:0][1:0]   in_vals2;
  logic [1:0]        in_nospike2;
  logic              grst2;
  logic [1:0]        input_spikes2;
  logic              wave_done2;
  logic              busy2;

  spike_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vals      (in_vals),
    .in_nospike   (in_nospike),
    .grst         (grst),
    .input_spikes (input_spikes),
    .wave_done    (wave_done),
    .busy         (busy)
  );

  spike_encoder #(
    .INP       (2),
    .TRES      (2),
    .WRES      (4),
    .GAMMA_LEN (19)
  ) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .in_valid     (in_valid2),
    .in_ready     (in_ready2),
    .in_vals      (in_vals2),
    .in_nospike   (in_nospike2),
    .grst         (grst2),
    .input_spikes (input_spikes2),
    .wave_done    (wave_done2),
    .busy         (busy2)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          grst_cyc = 0;
  logic [15:0] tr0;
  logic [15:0] tr7;
  logic [15:0] spk_or;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Channel i is high when unmasked and v_i <= t <= v_i + 7 (PW = 8).
  function automatic logic [15:0] exp_spk(input logic [15:0][2:0] v, input logic [15:0] ns, input int t);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!ns[i] && int'(v[i]) <= t && t <= int'(v[i]) + 7) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Called in a cycle where the DUT should accept the vector v/ns already on the inputs.
  // Ends in the wave's t=15 cycle with nxt_* on the inputs, so the caller decides what the next edge does.
  task automatic run_wave(input logic [15:0][2:0] v, input logic [15:0] ns,
                          input logic nxt_valid, input logic [15:0][2:0] nxt_v,
                          input logic [15:0] nxt_ns, input bit scramble, input string tag);
    chk({tag, "_rdy_at_accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid   = nxt_valid;
    in_vals    = nxt_v;
    in_nospike = nxt_ns;
    grst_cyc   = cyc;
    chk({tag, "_grst"}, 32'(grst), 32'd1);
    chk({tag, "_grst_spk"}, 32'(input_spikes), 32'd0);
    chk({tag, "_grst_busy"}, 32'(busy), 32'd1);
    chk({tag, "_grst_rdy"}, 32'(in_ready), 32'd0);
    tr0    = '0;
    tr7    = '0;
    spk_or = '0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (scramble && t != 15) begin
        for (int i = 0; i < 16; i++) in_vals[i] = 3'($urandom_range(0, 7));
        in_nospike = 16'($urandom);
      end else begin
        in_vals    = nxt_v;
        in_nospike = nxt_ns;
      end
      chk($sformatf("%s_spk_t%0d", tag, t), 32'(input_spikes), 32'(exp_spk(v, ns, t)));
      chk($sformatf("%s_done_t%0d", tag, t), 32'(wave_done), 32'(t == 15));
      chk($sformatf("%s_rdy_t%0d", tag, t), 32'(in_ready), 32'(t == 15));
      chk($sformatf("%s_grst_t%0d", tag, t), 32'(grst), 32'd0);
      tr0[t] = input_spikes[0];
      tr7[t] = input_spikes[7];
      spk_or = spk_or | input_spikes;
    end
  endtask

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [15:0][2:0] va;
    logic [15:0][2:0] vb;
    logic [15:0][2:0] vc;
    logic [15:0][2:0] vd;
    logic [15:0]      nsa;
    logic [15:0]      nsb;
    logic [15:0]      nsc;
    logic [15:0]      nsd;
    int               g1;
    int               done_cnt;
    int               busy_cnt;
    int               cnt2;

    rst = 1'b1; in_valid = 1'b0; in_vals = '0; in_nospike = '0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_vals2 = '0; in_nospike2 = '0;
    tick();
    tick();
    rst = 1'b0;
    rst2 = 1'b0;

    // Reset state.
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_grst", 32'(grst), 32'd0);
    chk("rst_spk", 32'(input_spikes), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(wave_done), 32'd0);
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grst", 32'(grst), 32'd0);
    chk("idle_spk", 32'(input_spikes), 32'd0);

    // Single wave: ch0..7 take values 0..7, ch8..15 masked with a nonzero value.
    for (int i = 0; i < 16; i++) va[i] = (i < 8) ? 3'(i) : 3'd5;
    nsa = 16'hFF00;
    in_vals = va; in_nospike = nsa; in_valid = 1'b1;
    run_wave(va, nsa, 1'b0, va, nsa, 1'b0, "single");
    chk("single_ch0_trace", 32'(tr0), 32'h0000_00FF);
    chk("single_ch7_trace", 32'(tr7), 32'h0000_7F80);
    chk("single_masked_hi", 32'(spk_or[15:8]), 32'd0);
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_rdy", 32'(in_ready), 32'd1);
    chk("single_idle_spk", 32'(input_spikes), 32'd0);
    chk("single_idle_done", 32'(wave_done), 32'd0);

    // Back-to-back: in_valid held, second vector presented once the first is accepted.
    for (int i = 0; i < 16; i++) vb[i] = 3'(7 - (i % 8));
    nsb = 16'h0000;
    for (int i = 0; i < 16; i++) vc[i] = 3'((i * 3) % 8);
    nsc = 16'hA5A5;
    in_vals = vb; in_nospike = nsb; in_valid = 1'b1;
    run_wave(vb, nsb, 1'b1, vc, nsc, 1'b0, "b2b1");
    g1 = grst_cyc;
    run_wave(vc, nsc, 1'b0, vc, nsc, 1'b0, "b2b2");
    chk("b2b_grst_spacing", 32'(grst_cyc - g1), 32'd17);
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // Input stability: inputs scrambled every cycle while the wave runs.
    for (int i = 0; i < 16; i++) vd[i] = 3'((i + 2) % 8);
    nsd = 16'h0F0F;
    in_vals = vd; in_nospike = nsd; in_valid = 1'b1;
    run_wave(vd, nsd, 1'b0, vd, nsd, 1'b1, "stab");
    tick();
    chk("stab_idle_busy", 32'(busy), 32'd0);

    // Reset at t=5 aborts the wave.
    in_vals = va; in_nospike = 16'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_grst", 32'(grst), 32'd1);
    repeat (6) tick();
    chk("mid_spk_t5", 32'(input_spikes), 32'(exp_spk(va, 16'h0000, 5)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_spk", 32'(input_spikes), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(wave_done), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      done_cnt += int'(wave_done);
      busy_cnt += int'(busy);
    end
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    chk("mid_no_busy", 32'(busy_cnt), 32'd0);
    in_vals = vb; in_nospike = 16'h3C3C; in_valid = 1'b1;
    run_wave(vb, 16'h3C3C, 1'b0, vb, 16'h3C3C, 1'b0, "post_rst");
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Sweep instance: value 3, PW=16, GAMMA_LEN=19 -> high on t=3..18.
    in_vals2[0] = 2'd3;
    in_vals2[1] = 2'd1;
    in_nospike2 = 2'b10;
    in_valid2 = 1'b1;
    chk("sw_rdy", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    in_vals2 = '0;
    chk("sw_grst", 32'(grst2), 32'd1);
    chk("sw_grst_spk", 32'(input_spikes2), 32'd0);
    cnt2 = 0;
    for (int t = 0; t < 19; t++) begin
      tick();
      chk($sformatf("sw_spk_t%0d", t), 32'(input_spikes2), 32'(t >= 3));
      chk($sformatf("sw_done_t%0d", t), 32'(wave_done2), 32'(t == 18));
      cnt2 += int'(input_spikes2[0]);
    end
    chk("sw_width", 32'(cnt2), 32'd16);
    tick();
    chk("sw_idle_busy", 32'(busy2), 32'd0);
    chk("sw_idle_spk", 32'(input_spikes2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
